// File: rtl/ioring_rx.sv
// ioring_rx: serial-to-parallel receiver with a ready/valid output register.
// Bits arrive MSB first on ser_in; ser_sync marks the bit time carrying the MSB.
// A clock-enable tick from a divider paces sampling, so there are no derived clocks.
// Optional feature: define IORING_RX_PARITY_EN to expect one trailing even-parity
// bit per frame and report a mismatch on parity_err.
module ioring_rx #(
  parameter int NUM_STAGES = 4,
  parameter int CLK_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ser_in,
  input  logic                  ser_sync,
  input  logic                  data_ready,
  input  logic                  ovr_clr,
  output logic [NUM_STAGES-1:0] data_out,
  output logic                  data_valid,
  output logic                  overrun,
  output logic                  parity_err
);

`ifdef IORING_RX_PARITY_EN
  localparam int FRAME_LEN = NUM_STAGES + 1;
`else
  localparam int FRAME_LEN = NUM_STAGES;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int DIV_W = 16;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [NUM_STAGES-1:0] shreg_q, shreg_d;
  logic [NUM_STAGES-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  tick;
  logic                  word_done;

`ifdef IORING_RX_PARITY_EN
  logic                  parity_err_q, parity_err_d;
`endif

  // Bit-time divider: free-running count that wraps at CLK_DIV-1 and flags the sampling cycle.
  always_comb begin
    tick      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  // Frame FSM: a sync tick (re)starts a frame; each later tick places the next bit at its final position.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    if (tick) begin
      if (ser_sync) begin
        state_d                = SHIFT;
        bit_cnt_d              = CNT_W'(1);
        shreg_d                = '0;
        shreg_d[NUM_STAGES-1]  = ser_in;
      end else if (state_q == SHIFT) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (bit_cnt_q == CNT_W'(NUM_STAGES - 1 - i)) begin
            shreg_d[i] = ser_in;
          end
        end
        if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          word_done = 1'b1;
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end
  end

  // Output register: accept a finished word when the slot is free or being drained, otherwise flag overrun.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
`ifdef IORING_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (word_done) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shreg_d;
        data_valid_d = 1'b1;
`ifdef IORING_RX_PARITY_EN
        parity_err_d = (^shreg_d) ^ ser_in;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef IORING_RX_PARITY_EN
  // Parity flag register, loaded together with data_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ioring_rx.sv
// tb_ioring_rx: directed bench for ioring_rx. Instance "dut" (CLK_DIV=1) feeds a
// scoreboard queue checked by a monitor; instance "dut_b" (CLK_DIV=3) covers the
// divided bit timing and mid-word reset.
module tb_ioring_rx;

`ifdef IORING_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FL = 4 + PAR_EN;

  typedef struct {
    logic [3:0] data;
    logic       perr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ser_in;
  logic       ser_sync;
  logic       data_ready;
  logic       ovr_clr;
  logic [3:0] data_out;
  logic       data_valid;
  logic       overrun;
  logic       parity_err;

  logic       rst_b;
  logic       ser_in_b;
  logic       ser_sync_b;
  logic       data_ready_b;
  logic       ovr_clr_b;
  logic [3:0] data_out_b;
  logic       data_valid_b;
  logic       overrun_b;
  logic       parity_err_b;

  int         errors;
  int         checks;
  exp_t       exp_q[$];
  logic [3:0] cur_exp;
  logic       cur_perr;

  ioring_rx #(.NUM_STAGES(4), .CLK_DIV(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .ser_sync   (ser_sync),
    .data_ready (data_ready),
    .ovr_clr    (ovr_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  ioring_rx #(.NUM_STAGES(4), .CLK_DIV(3)) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .ser_in     (ser_in_b),
    .ser_sync   (ser_sync_b),
    .data_ready (data_ready_b),
    .ovr_clr    (ovr_clr_b),
    .data_out   (data_out_b),
    .data_valid (data_valid_b),
    .overrun    (overrun_b),
    .parity_err (parity_err_b)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Present one bit for one clk (CLK_DIV=1 instance), return #1 after the sampling edge.
  task automatic applyStimulus(input logic sync, input logic b);
    ser_sync = sync;
    ser_in   = b;
    @(posedge clk);
    #1;
    ser_sync = 1'b0;
  endtask

  // Send a full frame MSB first; optionally raise data_ready in the final bit cycle.
  task automatic sendWord(input logic [3:0] w, input bit ready_last, input bit bad_par);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0 && PAR_EN == 0 && ready_last) data_ready = 1'b1;
      applyStimulus(i == 3, w[i]);
    end
    if (PAR_EN != 0) begin
      if (ready_last) data_ready = 1'b1;
      applyStimulus(1'b0, (^w) ^ bad_par);
    end
  endtask

  task automatic drain();
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a new word is presented and checks the held word every valid cycle.
  initial begin
    logic v_prev;
    logic r_prev;
    exp_t item;
    v_prev   = 1'b0;
    r_prev   = 1'b0;
    cur_exp  = '0;
    cur_perr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        v_prev = 1'b0;
        r_prev = 1'b0;
      end else begin
        if (data_valid && !(v_prev && !r_prev)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_word: got %0h, expected no word", data_out);
          end else begin
            item     = exp_q.pop_front();
            cur_exp  = item.data;
            cur_perr = item.perr;
          end
        end
        if (data_valid) begin
          checkOutput("mon_data_out", 32'(data_out), 32'(cur_exp));
          checkOutput("mon_parity_err", 32'(parity_err), 32'(cur_perr));
        end
        v_prev = data_valid;
        r_prev = data_ready;
      end
    end
  end

  // Main directed sequence.
  initial begin
    logic [3:0] wb;
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    rst_b        = 1'b1;
    ser_in       = 1'b0;
    ser_sync     = 1'b0;
    data_ready   = 1'b0;
    ovr_clr      = 1'b0;
    ser_in_b     = 1'b0;
    ser_sync_b   = 1'b0;
    data_ready_b = 1'b0;
    ovr_clr_b    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data_out", 32'(data_out), 32'h0);
    checkOutput("reset_data_valid", 32'(data_valid), 32'h0);
    checkOutput("reset_overrun", 32'(overrun), 32'h0);
    checkOutput("reset_parity_err", 32'(parity_err), 32'h0);
    rst   = 1'b0;
    rst_b = 1'b0;

    // Divided instance: each bit held 3 clks, aligned to the divider restart at reset release.
    $display("[TB] CLK_DIV=3 word 1001");
    wb = 4'b1001;
    for (int j = 0; j < FL; j++) begin
      ser_sync_b = (j == 0);
      ser_in_b   = (j < 4) ? wb[3-j] : (^wb);
      for (int c = 0; c < 3; c++) begin
        if (j == FL - 1 && c == 2) checkOutput("b_valid_before_tick", 32'(data_valid_b), 32'h0);
        @(posedge clk);
        #1;
      end
    end
    ser_sync_b = 1'b0;
    checkOutput("b_valid_after_tick", 32'(data_valid_b), 32'h1);
    checkOutput("b_data_out", 32'(data_out_b), 32'h9);
    checkOutput("b_parity_err", 32'(parity_err_b), 32'h0);

    $display("[TB] CLK_DIV=3 reset mid-word");
    ser_sync_b = 1'b1;
    ser_in_b   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ser_sync_b = 1'b0;
    ser_in_b   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    #1;
    checkOutput("b_rst_data_out", 32'(data_out_b), 32'h0);
    checkOutput("b_rst_data_valid", 32'(data_valid_b), 32'h0);
    checkOutput("b_rst_overrun", 32'(overrun_b), 32'h0);
    checkOutput("b_rst_parity_err", 32'(parity_err_b), 32'h0);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    for (int c = 0; c < 3 * FL + 3; c++) begin
      ser_in_b = c[0];
      @(posedge clk);
      #1;
    end
    checkOutput("b_no_word_after_rst", 32'(data_valid_b), 32'h0);
    checkOutput("b_data_out_after_rst", 32'(data_out_b), 32'h0);

    $display("[TB] word 1011, ready low");
    checkOutput("a_valid_before_word", 32'(data_valid), 32'h0);
    exp_q.push_back('{data: 4'b1011, perr: 1'b0});
    sendWord(4'b1011, 1'b0, 1'b0);
    checkOutput("a_valid_latency", 32'(data_valid), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("a_valid_held", 32'(data_valid), 32'h1);

    $display("[TB] word 0110 dropped while 1011 pending");
    sendWord(4'b0110, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("a_overrun_set", 32'(overrun), 32'h1);
    checkOutput("a_valid_kept", 32'(data_valid), 32'h1);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    checkOutput("a_overrun_cleared", 32'(overrun), 32'h0);

    $display("[TB] word 0110 replaces 1011 with ready in completion cycle");
    exp_q.push_back('{data: 4'b0110, perr: 1'b0});
    sendWord(4'b0110, 1'b1, 1'b0);
    data_ready = 1'b0;
    checkOutput("a_valid_after_replace", 32'(data_valid), 32'h1);
    checkOutput("a_no_overrun_replace", 32'(overrun), 32'h0);
    @(posedge clk);
    #1;
    drain();
    checkOutput("a_valid_drained", 32'(data_valid), 32'h0);

    $display("[TB] resync discards partial word");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    exp_q.push_back('{data: 4'b0001, perr: 1'b0});
    sendWord(4'b0001, 1'b0, 1'b0);
    checkOutput("a_valid_resync", 32'(data_valid), 32'h1);
    @(posedge clk);
    #1;
    drain();
    checkOutput("a_valid_drained2", 32'(data_valid), 32'h0);

    $display("[TB] word 1011 with corrupted parity bit");
    exp_q.push_back('{data: 4'b1011, perr: (PAR_EN != 0)});
    sendWord(4'b1011, 1'b0, 1'b1);
    checkOutput("a_valid_parity_word", 32'(data_valid), 32'h1);
    @(posedge clk);
    #1;
    drain();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    checkOutput("a_final_overrun", 32'(overrun), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ioring_rx.md
IORING_RX -- requirements
Module: ioring_rx

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 4, giving the width of the received word (legal range 2..32).
REQ-002 The block SHALL have parameter CLK_DIV, default 1, giving the number of clk cycles per serial bit (legal range 1..65535).
REQ-003 The block SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port ser_in  input  1  serial data line, MSB first.
REQ-006 The block SHALL have port ser_sync  input  1  frame marker, high on the bit time carrying a word's MSB.
REQ-007 The block SHALL have port data_ready  input  1  downstream accepts data_out.
REQ-008 The block SHALL have port ovr_clr  input  1  synchronous clear of the overrun flag.
REQ-009 The block SHALL have port data_out  output  NUM_STAGES  last completed word.
REQ-010 The block SHALL have port data_valid  output  1  data_out holds an unaccepted word.
REQ-011 The block SHALL have port overrun  output  1  sticky: a completed word was dropped.
REQ-012 The block SHALL have port parity_err  output  1  parity mismatch on the word in data_out.

Function
REQ-013 The bit tick SHALL be a divider counter 0..CLK_DIV-1 asserting tick when count==CLK_DIV-1; with CLK_DIV=1 tick SHALL be high every cycle; no derived clocks.
REQ-014 ser_in and ser_sync SHALL be sampled only on tick cycles.
REQ-015 The FSM SHALL have states IDLE, SHIFT; reset state IDLE.
REQ-016 IDLE: on tick with ser_sync=1, the FSM SHALL load ser_in as bit NUM_STAGES-1, set bit count to 1, go to SHIFT; ticks with ser_sync=0 are ignored.
REQ-017 SHIFT: each tick SHALL shift ser_in in as the next lower bit and increment the count.
REQ-018 SHIFT: a tick with ser_sync=1 SHALL discard the partial word and restart as in REQ-016.
REQ-019 Word completion SHALL occur on the tick sampling bit 0 (parity bit when REQ-027 applies); the FSM SHALL return to IDLE on that tick.
REQ-020 On completion with data_valid=0, or data_valid=1 and data_ready=1 in the same cycle, the block SHALL load data_out and assert data_valid on the next rising edge (latency 1 clk after the final sampling tick).
REQ-021 On completion with data_valid=1 and data_ready=0, the new word SHALL be dropped, data_out retained, and overrun set on the next edge.
REQ-022 data_valid SHALL clear on the edge after data_valid=1 and data_ready=1 unless REQ-020 reloads in the same cycle.
REQ-023 data_out SHALL remain stable while data_valid=1 and data_ready=0.
REQ-024 overrun SHALL clear on the edge after ovr_clr=1; a simultaneous set event SHALL take priority (overrun stays 1).

Reset
REQ-025 While rst=1, the block SHALL force FSM=IDLE, divider count=0, bit count=0, shift register=0, data_out=0, data_valid=0, overrun=0, parity_err=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word; reception after release SHALL require a new ser_sync.

Configuration
REQ-027 With macro IORING_RX_PARITY_EN defined, each frame SHALL carry one extra even-parity bit after bit 0; parity_err SHALL be loaded with the mismatch result alongside data_out, and completion SHALL occur on the parity tick.
REQ-028 Without IORING_RX_PARITY_EN, frames SHALL be NUM_STAGES bits, no parity logic SHALL be present, and parity_err SHALL be tied 0.

Verification (NUM_STAGES=4, CLK_DIV=1 unless stated)
REQ-029 Sync on bit 1, serial 1,0,1,1, data_ready=0 -> data_out=4'b1011, data_valid=1 one clk after fourth bit, held stable.
REQ-030 Word 4'b1011 pending, data_ready=0, second word 0110 completes -> data_out stays 4'b1011, overrun=1; ovr_clr pulse -> overrun=0.
REQ-031 data_ready=1 in the completion cycle of a second word 0110 while 4'b1011 pending -> data_out=4'b0110, data_valid stays 1, overrun=0.
REQ-032 Sync, bits 1,1, then sync again with bits 0,0,0,1 -> data_out=4'b0001; partial word discarded.
REQ-033 CLK_DIV=3, word 1001 -> sampling every third clk, data_valid 1 clk after the 12th-cycle tick; rst pulse mid-word -> all outputs 0, no word produced.
REQ-034 IORING_RX_PARITY_EN, word 1011 with parity bit 1 -> parity_err=0; parity bit 0 -> parity_err=1.
